// File: rtl/grn_rd_engine_if.sv
// CCI-P channel types and the bundled bus (c0/c1 channels plus the line output stream).
// Latency: none, wiring only.  Backpressure: almost-full flags and out_ready travel inside the bundle.
package grn_ccip_pkg;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

endpackage

interface grn_rd_engine_if #(
    parameter int IDX_W = 16
);
    import grn_ccip_pkg::*;

    logic           c0TxAlmFull;
    t_if_ccip_c0_Rx rx_c0;
    t_if_ccip_c0_Tx tx_c0;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Tx tx_c1;
    logic           out_valid;
    logic           out_ready;
    logic [511:0]   out_data;
    logic [IDX_W-1:0] out_idx;

    // master = the read engine, slave = host shim plus line consumer
    modport master (
        input  c0TxAlmFull, rx_c0, c1TxAlmFull, out_ready,
        output tx_c0, tx_c1, out_valid, out_data, out_idx
    );

    modport slave (
        output c0TxAlmFull, rx_c0, c1TxAlmFull, out_ready,
        input  tx_c0, tx_c1, out_valid, out_data, out_idx
    );

endinterface

// File: rtl/grn_rd_engine.sv
// Generic synchronous FIFO with registered storage; read data comes straight from the array.
// Latency: a pushed entry is visible on out_vld the cycle after the push, never the same cycle.
// Backpressure: in_rdy drops when full; out_dat/out_vld hold until out_rdy pops the entry.
module grn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push;
    logic             pop;

    assign in_rdy  = (cnt != (AW+1)'(DEPTH));
    assign out_vld = (cnt != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// Host-to-AFU read DMA: streams buffer 0 over c0 reads, then writes a completion record to DSM.
// Latency: c0 request one cycle after the issue decision; returned lines leave no earlier than the cycle after arrival.
// Backpressure: issue stalls on c0TxAlmFull or zero credits; DSM write waits on c1TxAlmFull; lines held until out_ready.
module grn_rd_engine
    import grn_ccip_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 32,
    parameter int IDX_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hc_control,
    input  logic [41:0] hc_dsm_base,
    input  logic [41:0] buf_addr,
    input  logic [31:0] buf_size,
    grn_rd_engine_if.master bus,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FW = IDX_W + 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DSM_WR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        start_q;
    logic        start_edge;
    logic        start_go;
    logic        issue;
    logic        c1_fire;
    logic        pop;
    logic        rsp_en;
    logic        rsp_push;

    logic [41:0] base_q;
    logic [41:0] dsm_q;
    logic [31:0] size_q;
    logic [31:0] req_cnt;
    logic [31:0] pop_cnt;
    logic [CW-1:0] credits;

    logic          fifo_in_rdy;
    logic          fifo_out_vld;
    logic [FW-1:0] fifo_out_dat;

    logic        unused_ctl;
    assign unused_ctl = ^hc_control[31:1];

    assign start_edge = hc_control[0] && !start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        issue     = 1'b0;
        c1_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    start_go  = 1'b1;
                    state_nxt = (buf_size == 32'd0) ? S_DSM_WR : S_RUN;
                end
            end
            S_RUN: begin
                if (req_cnt == size_q) begin
                    state_nxt = S_DRAIN;
                end else if (!bus.c0TxAlmFull && (credits != '0)) begin
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pop_cnt == size_q) begin
                    state_nxt = S_DSM_WR;
                end
            end
            S_DSM_WR: begin
                if (!bus.c1TxAlmFull) begin
                    c1_fire   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!hc_control[0]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            rsp_en  <= 1'b0;
            base_q  <= '0;
            dsm_q   <= '0;
            size_q  <= '0;
            req_cnt <= '0;
            pop_cnt <= '0;
            credits <= CW'(MAX_OUTSTANDING);
        end else begin
            start_q <= hc_control[0];
            if (start_go) begin
                base_q  <= buf_addr;
                dsm_q   <= hc_dsm_base;
                size_q  <= buf_size;
                req_cnt <= '0;
                pop_cnt <= '0;
                credits <= CW'(MAX_OUTSTANDING);
                rsp_en  <= 1'b1;
            end else begin
                if (issue) begin
                    req_cnt <= req_cnt + 32'd1;
                end
                if (pop) begin
                    pop_cnt <= pop_cnt + 32'd1;
                end
                // a credit covers a line from request until the consumer takes it
                case ({issue, pop})
                    2'b10:   credits <= credits - CW'(1);
                    2'b01:   credits <= credits + CW'(1);
                    default: credits <= credits;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.tx_c0 <= '0;
            bus.tx_c1 <= '0;
        end else begin
            bus.tx_c0.valid         <= issue;
            bus.tx_c0.hdr.address   <= base_q + 42'(req_cnt);
            bus.tx_c0.hdr.mdata     <= 16'(req_cnt[IDX_W-1:0]);
            bus.tx_c1.valid         <= c1_fire;
            bus.tx_c1.hdr.address   <= dsm_q;
            bus.tx_c1.hdr.mdata     <= '0;
            bus.tx_c1.data          <= {448'b0, pop_cnt, 31'b0, 1'b1};
        end
    end

    // responses to requests issued before a reset are discarded until the next start
    assign rsp_push = bus.rx_c0.rspValid && (bus.rx_c0.hdr.resp_type == eRSP_RDLINE) && rsp_en;

    grn_fifo #(
        .WIDTH (FW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rsp_push),
        .in_rdy  (fifo_in_rdy),
        .in_dat  ({bus.rx_c0.hdr.mdata[IDX_W-1:0], bus.rx_c0.data}),
        .out_vld (fifo_out_vld),
        .out_rdy (bus.out_ready),
        .out_dat (fifo_out_dat)
    );

    assign bus.out_valid                = fifo_out_vld;
    assign {bus.out_idx, bus.out_data}  = fifo_out_dat;
    assign pop                          = bus.out_valid && bus.out_ready;

    assign busy = (state == S_RUN) || (state == S_DRAIN) || (state == S_DSM_WR);
    assign done = (state == S_DONE);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(rsp_push && !fifo_in_rdy));

endmodule

// File: tb/tb_grn_rd_engine.sv
// Bench for grn_rd_engine: table of transfers plus hand-built credit, almost-full and abort sequences.
module tb_grn_rd_engine;
    import grn_ccip_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hc_control;
    logic [41:0] hc_dsm_base;
    logic [41:0] buf_addr;
    logic [31:0] buf_size;
    logic        busy;
    logic        done;

    grn_rd_engine_if #(.IDX_W(16)) u ();

    grn_rd_engine #(
        .MAX_OUTSTANDING (32),
        .IDX_W           (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hc_control  (hc_control),
        .hc_dsm_base (hc_dsm_base),
        .buf_addr    (buf_addr),
        .buf_size    (buf_size),
        .bus         (u.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] idx;
        logic [41:0] addr;
    } req_t;

    typedef struct packed {
        logic [15:0]  idx;
        logic [511:0] dat;
    } line_t;

    typedef struct {
        logic [41:0] addr;
        logic [31:0] size;
        logic [41:0] dsm;
        logic [7:0]  perm;
        int          rdy_mode;
        logic [31:0] exp_cnt;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    req_t  pending[$];
    req_t  burst[$];
    req_t  stale[$];
    line_t sb[$];
    vec_t  vt[5];

    logic [41:0]  cur_base;
    logic [31:0]  cur_size;
    logic [31:0]  req_seen;
    logic [31:0]  pop_seen;
    int           c1_cnt;
    int           stray_vld;
    logic [41:0]  c1_addr;
    logic [511:0] c1_dat;
    logic [7:0]   perm;
    int           rdy_mode;
    bit           rsp_hold;

    function automatic logic [511:0] line_of(logic [41:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = a[31:0] ^ {i[3:0], a[41:32], 18'h2A5A5};
        end
        return d;
    endfunction

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_rsp(req_t r);
        u.rx_c0.rspValid      = 1'b1;
        u.rx_c0.hdr.resp_type = eRSP_RDLINE;
        u.rx_c0.hdr.mdata     = r.idx;
        u.rx_c0.data          = line_of(r.addr);
    endtask

    // one clock: sample DUT after the edge, then drive consumer and memory-side responder
    task automatic step();
        req_t  r;
        line_t l;
        req_t  t[4];
        @(posedge clk);
        #1;
        cyc++;
        if (u.tx_c0.valid === 1'b1) begin
            chk("c0_addr", 512'(u.tx_c0.hdr.address), 512'(cur_base + 42'(req_seen)));
            chk("c0_mdata", 512'(u.tx_c0.hdr.mdata), 512'(req_seen[15:0]));
            r.idx  = req_seen[15:0];
            r.addr = cur_base + 42'(req_seen);
            pending.push_back(r);
            req_seen++;
        end
        if (u.tx_c1.valid === 1'b1) begin
            c1_cnt++;
            c1_addr = u.tx_c1.hdr.address;
            c1_dat  = u.tx_c1.data;
        end
        case (rdy_mode)
            0:       u.out_ready = 1'b1;
            1:       u.out_ready = 1'b0;
            default: u.out_ready = cyc[0];
        endcase
        if (u.out_valid === 1'b1 && u.out_ready) begin
            pop_seen++;
            if (sb.size() == 0) begin
                stray_vld++;
            end else begin
                l = sb.pop_front();
                chk("out_idx", 512'(u.out_idx), 512'(l.idx));
                chk("out_data", u.out_data, l.dat);
            end
        end
        u.rx_c0 = '0;
        if (stale.size() > 0) begin
            drive_rsp(stale.pop_front());
        end else if (!rsp_hold) begin
            if (burst.size() == 0) begin
                if (pending.size() >= 4) begin
                    for (int k = 0; k < 4; k++) t[k] = pending.pop_front();
                    for (int k = 0; k < 4; k++) burst.push_back(t[perm[2*k +: 2]]);
                end else if (req_seen == cur_size) begin
                    while (pending.size() > 0) burst.push_back(pending.pop_front());
                end
            end
            if (burst.size() > 0) begin
                r = burst.pop_front();
                drive_rsp(r);
                l.idx = r.idx;
                l.dat = line_of(r.addr);
                sb.push_back(l);
            end
        end
    endtask

    task automatic start_xfer(logic [41:0] addr, logic [31:0] size, logic [41:0] dsm);
        cur_base  = addr;
        cur_size  = size;
        req_seen  = 0;
        pop_seen  = 0;
        c1_cnt    = 0;
        stray_vld = 0;
        c1_addr   = '0;
        c1_dat    = '0;
        pending.delete();
        burst.delete();
        buf_addr    = addr;
        buf_size    = size;
        hc_dsm_base = dsm;
        hc_control  = 32'h8000_0001;
        step();
        chk("busy_after_start", 512'(busy), 512'(1));
        // the running transfer must keep its latched buffer description
        buf_addr    = 42'h0;
        buf_size    = 32'd1;
        hc_dsm_base = 42'h0;
    endtask

    task automatic finish_xfer(logic [31:0] exp_cnt, logic [41:0] dsm, int budget);
        for (int n = 0; n < budget && done !== 1'b1; n++) step();
        chk("done_reached", 512'(done), 512'(1));
        chk("busy_in_done", 512'(busy), 512'(0));
        chk("req_count", 512'(req_seen), 512'(cur_size));
        chk("pop_count", 512'(pop_seen), 512'(exp_cnt));
        chk("c1_writes", 512'(c1_cnt), 512'(1));
        chk("dsm_addr", 512'(c1_addr), 512'(dsm));
        chk("dsm_flag", 512'(c1_dat[0]), 512'(1));
        chk("dsm_count", 512'(c1_dat[63:32]), 512'(exp_cnt));
        chk("dsm_rest", 512'({c1_dat[511:64], c1_dat[31:1]}), 512'(0));
        chk("stray_lines", 512'(stray_vld), 512'(0));
        chk("sb_empty", 512'(sb.size()), 512'(0));
        hc_control = 32'h0;
        step();
        chk("done_clear", 512'(done), 512'(0));
        step();
        step();
        chk("c1_single", 512'(c1_cnt), 512'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int    viol;
        int    seen_vld;
        logic [31:0] base_req;

        vt[0] = '{addr: 42'h1000,        size: 32'd4, dsm: 42'h2000, perm: 8'hE4, rdy_mode: 0, exp_cnt: 32'd4};
        vt[1] = '{addr: 42'h3_FFFF_FFFE, size: 32'd4, dsm: 42'h2100, perm: 8'h72, rdy_mode: 0, exp_cnt: 32'd4};
        vt[2] = '{addr: 42'h2000,        size: 32'd0, dsm: 42'h2200, perm: 8'hE4, rdy_mode: 0, exp_cnt: 32'd0};
        vt[3] = '{addr: 42'h4000,        size: 32'd7, dsm: 42'h2300, perm: 8'h1B, rdy_mode: 2, exp_cnt: 32'd7};
        vt[4] = '{addr: 42'h5000,        size: 32'd9, dsm: 42'h2400, perm: 8'hE4, rdy_mode: 2, exp_cnt: 32'd9};

        reset         = 1'b1;
        hc_control    = 32'h0;
        hc_dsm_base   = '0;
        buf_addr      = '0;
        buf_size      = '0;
        u.c0TxAlmFull = 1'b0;
        u.c1TxAlmFull = 1'b0;
        u.out_ready   = 1'b0;
        u.rx_c0       = '0;
        rdy_mode      = 1;
        rsp_hold      = 1'b0;
        perm          = 8'hE4;
        cur_base      = '0;
        cur_size      = '0;
        req_seen      = '0;
        pop_seen      = '0;
        c1_cnt        = 0;
        stray_vld     = 0;
        repeat (3) step();
        chk("rst_c0_valid", 512'(u.tx_c0.valid), 512'(0));
        chk("rst_c1_valid", 512'(u.tx_c1.valid), 512'(0));
        chk("rst_out_valid", 512'(u.out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            perm     = vt[i].perm;
            rdy_mode = vt[i].rdy_mode;
            start_xfer(vt[i].addr, vt[i].size, vt[i].dsm);
            finish_xfer(vt[i].exp_cnt, vt[i].dsm, 400);
        end

        // credit limit: consumer stalled, only MAX_OUTSTANDING reads may go out
        perm     = 8'hE4;
        rdy_mode = 1;
        start_xfer(42'h8000, 32'd100, 42'h9000);
        repeat (120) step();
        chk("credit_stall_reqs", 512'(req_seen), 512'(32));
        chk("credit_stall_vld", 512'(u.out_valid), 512'(1));
        chk("credit_stall_busy", 512'(busy), 512'(1));
        rdy_mode = 0;
        finish_xfer(32'd100, 42'h9000, 2000);

        // c0 almost-full window mid-RUN, c1 almost-full holding the DSM write
        rdy_mode      = 0;
        u.c1TxAlmFull = 1'b1;
        start_xfer(42'h1_0000, 32'd40, 42'hA000);
        for (int n = 0; n < 50 && req_seen < 8; n++) step();
        u.c0TxAlmFull = 1'b1;
        base_req      = req_seen;
        viol          = 0;
        repeat (10) begin
            step();
            if (u.tx_c0.valid !== 1'b0) viol++;
        end
        u.c0TxAlmFull = 1'b0;
        chk("c0_af_quiet", 512'(viol), 512'(0));
        chk("c0_af_noreq", 512'(req_seen), 512'(base_req));
        for (int n = 0; n < 300 && pop_seen < 40; n++) step();
        repeat (8) step();
        chk("c1_af_hold", 512'(c1_cnt), 512'(0));
        chk("c1_af_busy", 512'(busy), 512'(1));
        u.c1TxAlmFull = 1'b0;
        finish_xfer(32'd40, 42'hA000, 100);

        // abort with lines in flight; their late responses must vanish
        rsp_hold = 1'b1;
        start_xfer(42'h2_0000, 32'd16, 42'hB000);
        for (int n = 0; n < 40 && req_seen < 5; n++) step();
        chk("abort_inflight", 512'(req_seen), 512'(5));
        chk("abort_busy_before", 512'(busy), 512'(1));
        reset      = 1'b1;
        hc_control = 32'h0;
        step();
        chk("abort_c0_valid", 512'(u.tx_c0.valid), 512'(0));
        chk("abort_c1_valid", 512'(u.tx_c1.valid), 512'(0));
        chk("abort_out_valid", 512'(u.out_valid), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_done", 512'(done), 512'(0));
        reset = 1'b0;
        while (pending.size() > 0) stale.push_back(pending.pop_front());
        seen_vld = 0;
        repeat (12) begin
            step();
            if (u.out_valid !== 1'b0) seen_vld++;
        end
        chk("stale_dropped", 512'(seen_vld), 512'(0));
        chk("stale_no_busy", 512'(busy), 512'(0));
        rsp_hold = 1'b0;

        perm     = 8'h72;
        rdy_mode = 2;
        start_xfer(42'h3_0000, 32'd6, 42'hC000);
        finish_xfer(32'd6, 42'hC000, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grn_rd_engine.md
Name: grn_rd_engine

Overview:
Host-to-AFU read DMA engine. It sits directly downstream of the CSR block and consumes its control word, buffer descriptor 0 and DSM base. On a start command it issues CCI-P c0 cache-line reads over buffer 0 and streams the returned lines to the compute pipeline. When all lines have been consumed, it writes a completion record to the DSM line.

Parameters:
MAX_OUTSTANDING, 32, maximum c0 reads in flight plus lines buffered; power of 2, 2..64
IDX_W, 16, width of the line-index tag carried in mdata and on the output stream

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
hc_control  in  32  control word; bit0 = start (level), other bits ignored
hc_dsm_base  in  42  DSM cache-line address
buf_addr  in  42  buffer 0 base cache-line address
buf_size  in  32  buffer 0 length in cache lines
c0TxAlmFull  in  1  c0 request channel almost full
rx_c0  in  t_if_ccip_c0_Rx  read responses; rspValid, hdr.mdata, data
tx_c0  out  t_if_ccip_c0_Tx  read requests; valid, hdr.address, hdr.mdata
c1TxAlmFull  in  1  c1 request channel almost full
tx_c1  out  t_if_ccip_c1_Tx  DSM write request
out_valid  out  1  output line valid
out_ready  in  1  consumer accepts line
out_data  out  512  line payload
out_idx  out  IDX_W  line index within buffer (0-based)
busy  out  1  engine not IDLE/DONE
done  out  1  completion record issued

Behaviour:
- Reset: FSM to IDLE. tx_c0.valid=0, tx_c1.valid=0, out_valid=0, busy=0, done=0. Counters and FIFO cleared. Reset mid-transfer aborts immediately. Responses arriving after reset for pre-reset requests are dropped until the next start.
- Start detect: rising edge of hc_control[0], registered internally. The edge is acted on only in IDLE. Edges in other states are ignored.
- On start, latch buf_addr, buf_size and hc_dsm_base. Later CSR writes do not affect the running transfer.
- FSM states: IDLE -> RUN (start, buf_size != 0); IDLE -> DSM_WR (start, buf_size == 0); RUN -> DRAIN (all requests issued); DRAIN -> DSM_WR (all lines popped by consumer); DSM_WR -> DONE (c1 write issued); DONE -> IDLE (hc_control[0] == 0).
- Request issue in RUN: one read per cycle when c0TxAlmFull == 0 and credits > 0.
  - Read address = base + req_cnt, 42-bit add, wrap-around ignored.
  - mdata[IDX_W-1:0] = req_cnt[IDX_W-1:0].
  - tx_c0 is registered: the request appears the cycle after the issue decision.
  - req_cnt increments per issue.
- Credits: starts at MAX_OUTSTANDING. Decrements on issue, increments on output pop. Simultaneous issue and pop leaves credits unchanged.
- Response FIFO:
  - Depth MAX_OUTSTANDING. Pushed on rx_c0.rspValid with a read response type, storing {mdata idx, data}.
  - Credits guarantee the FIFO never overflows; an overflow is an assertion failure.
  - Responses may arrive out of order, and the output order matches arrival order; out_idx identifies each line.
  - FIFO latency: a pushed line is presentable on out_valid at least 1 cycle after push. An empty-FIFO push may not bypass to the same cycle.
- Output handshake: pop when out_valid && out_ready. out_data and out_idx hold stable while out_valid=1 and out_ready=0.
- Line accounting: pop_cnt counts pops. DRAIN exits when pop_cnt == latched size.
- DSM_WR:
  - Wait for c1TxAlmFull == 0, then assert tx_c1.valid for exactly 1 cycle.
  - Address = latched dsm_base. Data[0] = 1, data[63:32] = pop_cnt, remaining bits 0.
- done: 1 in DONE only. busy: 1 in RUN, DRAIN and DSM_WR.
- buf_size > 2^IDX_W: the index wraps modulo 2^IDX_W, and the count remains 32-bit.

Test Plan:
- Basic transfer: buf_addr=0x1000, buf_size=4, start. Response returned in order, out_ready=1 -> 4 c0 reads at 0x1000..0x1003, out_idx 0..3, DSM write data[0]=1 and [63:32]=4, done=1.
- Out-of-order responses: size=4, responses returned with idx 2,0,3,1 -> output order 2,0,3,1 with matching data; completion count 4.
- Credit limit: MAX_OUTSTANDING=32, size=100, out_ready=0 -> exactly 32 reads issued and then a stall. After releasing out_ready, all 100 reads and pops complete; no overflow.
- Almost-full: c0TxAlmFull held high for 10 cycles mid-RUN -> no tx_c0.valid during the window plus 1 cycle; c1TxAlmFull high delays the single DSM write.
- Zero size: buf_size=0, start -> no c0 reads, DSM write with count 0, done=1.
- Restart and abort: restart after dropping hc_control[0] in DONE -> second transfer runs. Reset asserted in RUN with 5 lines in flight -> all outputs 0 next cycle; stale responses produce no out_valid.
